// File: rtl/systolic_pkg.sv
// Shared types and tile-length helpers for the systolic array front end.
package systolic_pkg;

    typedef enum logic [1:0] {
        StFeed  = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Zero shifts needed after the last beat so that the deepest lane empties.
    function automatic int unsigned drain_len(input int unsigned dim);
        return 2 * dim - 2;
    endfunction

    // Total array enable pulses in one tile: DIM beats plus the drain.
    function automatic int unsigned tile_en_pulses(input int unsigned dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One skew lane: a DEPTH-stage delay line that advances only on shift.
module skew_lane #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Delay line: all stages move together so lanes keep their relative skew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                r_stage[s] <= '0;
            end
        end else if (shift) begin
            r_stage[0] <= din;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign dout = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed A/B vectors into a DIMxDIM systolic MAC array and drains the
// tile with zeros before pulsing done.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIM*BITS_AB-1:0] a_vec,
    input  logic [DIM*BITS_AB-1:0] b_vec,
    input  logic                   hold,
    output logic [DIM*BITS_AB-1:0] A,
    output logic [DIM*BITS_AB-1:0] B,
    output logic                   en,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CNT_W = $clog2(2 * DIM + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(drain_len(DIM));

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [CNT_W-1:0]   r_drain_cnt, w_drain_cnt_nxt;
    logic               r_en, r_done;
    logic               w_shift, w_feed;

    assign w_feed = (r_state == StFeed);

    // State register and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StFeed;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // Next state, handshake and shift decision; hold blocks every shift.
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        in_ready        = 1'b0;
        w_shift         = 1'b0;
        unique case (r_state)
            StFeed: begin
                in_ready = ~hold;
                w_shift  = in_valid & ~hold;
                if (w_shift) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == LAST_BEAT) begin
                        if (DIM == 1) begin
                            w_state_nxt = StDone;
                        end else begin
                            w_state_nxt     = StDrain;
                            w_drain_cnt_nxt = DRAIN_INIT;
                        end
                    end
                end
            end
            StDrain: begin
                if (!hold) begin
                    w_shift         = 1'b1;
                    w_drain_cnt_nxt = r_drain_cnt - 1'b1;
                    if (r_drain_cnt == CNT_W'(1)) begin
                        w_state_nxt = StDone;
                    end
                end
            end
            StDone: begin
                w_state_nxt    = StFeed;
                w_beat_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = StFeed;
            end
        endcase
    end

    // en marks the cycle new skewed values appear; done follows the DONE state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_en   <= w_shift;
            r_done <= (r_state == StDone);
        end
    end

    assign en   = r_en;
    assign done = r_done;
    assign busy = (r_beat_cnt != '0) | (r_state == StDrain);

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        logic [BITS_AB-1:0] w_a_in, w_b_in;

        // Drain pushes zeros so every lane is empty at the next tile start.
        assign w_a_in = w_feed ? a_vec[g*BITS_AB +: BITS_AB] : '0;
        assign w_b_in = w_feed ? b_vec[g*BITS_AB +: BITS_AB] : '0;

        skew_lane #(
            .WIDTH(BITS_AB),
            .DEPTH(g + 1)
        ) u_lane_a (
            .clk  (clk),
            .rst  (rst),
            .shift(w_shift),
            .din  (w_a_in),
            .dout (A[g*BITS_AB +: BITS_AB])
        );

        skew_lane #(
            .WIDTH(BITS_AB),
            .DEPTH(g + 1)
        ) u_lane_b (
            .clk  (clk),
            .rst  (rst),
            .shift(w_shift),
            .din  (w_b_in),
            .dout (B[g*BITS_AB +: BITS_AB])
        );
    end

endmodule
